// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack memory port and
// hands the fetched word to decode, with a sticky fault on a memory timeout.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PC_Immed,
    input  logic        PC_sel,
    input  logic        PC_LdEn,
    output logic        Imem_req,
    output logic [31:0] Imem_addr,
    input  logic [31:0] Imem_rdata,
    input  logic        Imem_ack,
    output logic [31:0] Instr,
    output logic        Instr_valid,
    output logic [31:0] PC,
    output logic        Fetch_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned PC_W  = 32;
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HOLD = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PC_W-1:0]   branch_ofs;
    logic [PC_W-1:0]   next_pc;

    // Word offset scaled to bytes; the top two immediate bits fall off the shift.
    assign branch_ofs = PC_sel ? (PC_Immed << 2) : '0;
    assign next_pc    = pc_q + PC_W'(4) + branch_ofs;

    // Request is decoded from state so it drops together with an async reset.
    assign Imem_req    = (state_q == S_REQ) || (state_q == S_WAIT);
    assign Imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign Instr_valid = valid_q;
    assign PC          = pc_q;
    assign Fetch_err   = err_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            pc_q    <= RESET_PC;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                if (Imem_ack) begin
                    instr_d = Imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = CNT_W'(1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A late ack arriving on the limit cycle still completes the fetch.
                if (Imem_ack) begin
                    instr_d = Imem_rdata;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end else if (cnt_q == WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (PC_LdEn) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_ERR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed latency/branch/timeout/reset cases, then a
// randomized run with a PC model feeding a scoreboard checked by a monitor.
module tb_if_stage;

    localparam logic [31:0] WRAP_PC = 32'hFFFF_FFFC;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PC_Immed = '0;
    logic        PC_sel = 1'b0;
    logic        PC_LdEn = 1'b0;
    logic        Imem_req;
    logic [31:0] Imem_addr;
    logic [31:0] Imem_rdata = '0;
    logic        Imem_ack = 1'b0;
    logic [31:0] Instr;
    logic        Instr_valid;
    logic [31:0] PC;
    logic        Fetch_err;

    logic        w_reset = 1'b1;
    logic [31:0] w_imm = '0;
    logic        w_sel = 1'b0;
    logic        w_ld = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_ack = 1'b0;
    logic [31:0] w_instr;
    logic        w_valid;
    logic [31:0] w_pc;
    logic        w_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_pc;
    logic [31:0] cur_pc;
    logic        prev_v;
    int          n_fetch;

    always #5 Clk = ~Clk;

    if_stage dut (
        .Clk(Clk), .Reset(Reset), .PC_Immed(PC_Immed), .PC_sel(PC_sel), .PC_LdEn(PC_LdEn),
        .Imem_req(Imem_req), .Imem_addr(Imem_addr), .Imem_rdata(Imem_rdata), .Imem_ack(Imem_ack),
        .Instr(Instr), .Instr_valid(Instr_valid), .PC(PC), .Fetch_err(Fetch_err)
    );

    if_stage #(.RESET_PC(WRAP_PC), .MAX_WAIT(15)) dut_wrap (
        .Clk(Clk), .Reset(w_reset), .PC_Immed(w_imm), .PC_sel(w_sel), .PC_LdEn(w_ld),
        .Imem_req(w_req), .Imem_addr(w_addr), .Imem_rdata(w_rdata), .Imem_ack(w_ack),
        .Instr(w_instr), .Instr_valid(w_valid), .PC(w_pc), .Fetch_err(w_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Returns one cycle after release with the DUT presenting its first request.
    task automatic do_reset();
        Reset = 1'b1;
        PC_LdEn = 1'b0;
        Imem_ack = 1'b0;
        tick();
        check("rst_pc", PC, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_valid", 32'(Instr_valid), 32'd0);
        check("rst_req", 32'(Imem_req), 32'd0);
        check("rst_err", 32'(Fetch_err), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
    endtask

    // Serve the current request with d wait cycles, then check the captured word.
    task automatic fetch(input int d, input logic [31:0] exp_pc);
        for (int i = 0; i <= d; i++) begin
            check("fetch_req", 32'(Imem_req), 32'd1);
            check("fetch_addr", Imem_addr, exp_pc);
            check("fetch_notvalid", 32'(Instr_valid), 32'd0);
            Imem_ack = (i == d);
            Imem_rdata = (i == d) ? mem_word(exp_pc) : $urandom;
            tick();
        end
        Imem_ack = 1'b0;
        check("fetch_valid", 32'(Instr_valid), 32'd1);
        check("fetch_instr", Instr, mem_word(exp_pc));
        check("fetch_pc", PC, exp_pc);
        check("fetch_req_low", 32'(Imem_req), 32'd0);
        check("fetch_err", 32'(Fetch_err), 32'd0);
    endtask

    task automatic advance(input logic sel, input logic [31:0] imm,
                           input logic [31:0] old_pc, input logic [31:0] exp_pc);
        PC_sel = sel;
        PC_Immed = imm;
        PC_LdEn = 1'b1;
        tick();
        PC_LdEn = 1'b0;
        PC_sel = 1'($urandom);
        PC_Immed = $urandom;
        check("adv_pc", PC, exp_pc);
        check("adv_valid", 32'(Instr_valid), 32'd0);
        check("adv_instr_kept", Instr, mem_word(old_pc));
        check("adv_req", 32'(Imem_req), 32'd1);
    endtask

    task automatic rand_driver();
        int req_cnt = 0;
        int delay = 0;
        logic [31:0] imm;
        logic sel;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(posedge Clk);
            #1;
            if (Imem_req) begin
                if (req_cnt == 0) delay = $urandom_range(0, 6);
                Imem_ack = (req_cnt == delay);
                Imem_rdata = (req_cnt == delay) ? mem_word(Imem_addr) : $urandom;
                req_cnt++;
            end else begin
                req_cnt = 0;
                Imem_ack = ($urandom_range(0, 3) == 0);
                Imem_rdata = $urandom;
            end
            sel = 1'($urandom);
            imm = $urandom;
            if ($urandom_range(0, 1) == 1) imm = 32'($urandom_range(0, 64)) - 32'd32;
            PC_sel = sel;
            PC_Immed = imm;
            if (Instr_valid && $urandom_range(0, 2) != 0) begin
                PC_LdEn = 1'b1;
                model_pc = model_pc + 32'd4 + (sel ? imm * 32'd4 : 32'd0);
                exp_q.push_back(model_pc);
            end else begin
                PC_LdEn = !Instr_valid && ($urandom_range(0, 4) == 0);
            end
        end
    endtask

    task automatic rand_monitor();
        forever begin
            @(negedge Clk);
            if (Imem_req) begin
                if (exp_q.size() == 0) check("mon_req_unexpected", 32'(Imem_req), 32'd0);
                else check("mon_addr", Imem_addr, exp_q[0]);
            end
            if (Instr_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("mon_valid_unexpected", 32'(Instr_valid), 32'd0);
                end else begin
                    cur_pc = exp_q.pop_front();
                    n_fetch++;
                    check("mon_pc", PC, cur_pc);
                    check("mon_instr", Instr, mem_word(cur_pc));
                    check("mon_err", 32'(Fetch_err), 32'd0);
                end
            end else if (Instr_valid) begin
                check("mon_stall_instr", Instr, mem_word(cur_pc));
                check("mon_stall_pc", PC, cur_pc);
            end
            prev_v = Instr_valid;
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL global_timeout actual=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Sequential fetches with a zero-wait memory.
        do_reset();
        fetch(0, 32'h0);
        advance(1'b0, 32'h0, 32'h0, 32'h4);
        fetch(0, 32'h4);
        advance(1'b0, 32'h0, 32'h4, 32'h8);
        fetch(0, 32'h8);

        // Branches: forward, backward and forward again.
        advance(1'b1, 32'h1, 32'h8, 32'h10);
        fetch(0, 32'h10);
        advance(1'b1, 32'hFFFF_FFFE, 32'h10, 32'h0C);
        fetch(1, 32'h0C);
        advance(1'b1, 32'h3, 32'h0C, 32'h1C);

        // Slow ack, then a 5-cycle stall with stray acks that must be ignored.
        fetch(3, 32'h1C);
        for (int i = 0; i < 5; i++) begin
            Imem_ack = 1'b1;
            Imem_rdata = $urandom;
            tick();
            check("stall_instr", Instr, mem_word(32'h1C));
            check("stall_pc", PC, 32'h1C);
            check("stall_valid", 32'(Instr_valid), 32'd1);
            check("stall_req", 32'(Imem_req), 32'd0);
        end
        Imem_ack = 1'b0;
        advance(1'b0, 32'h0, 32'h1C, 32'h20);
        fetch(15, 32'h20);

        // No ack at all: REQ plus 15 WAIT cycles, then a sticky fault.
        advance(1'b0, 32'h0, 32'h20, 32'h24);
        for (int i = 0; i < 16; i++) begin
            check("to_req", 32'(Imem_req), 32'd1);
            check("to_addr", Imem_addr, 32'h24);
            check("to_err_early", 32'(Fetch_err), 32'd0);
            PC_LdEn = (i == 5);
            tick();
        end
        PC_LdEn = 1'b0;
        check("to_err", 32'(Fetch_err), 32'd1);
        check("to_req_low", 32'(Imem_req), 32'd0);
        check("to_valid", 32'(Instr_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            Imem_ack = 1'b1;
            Imem_rdata = $urandom;
            PC_LdEn = 1'b1;
            tick();
            check("err_sticky", 32'(Fetch_err), 32'd1);
            check("err_req", 32'(Imem_req), 32'd0);
            check("err_valid", 32'(Instr_valid), 32'd0);
            check("err_pc", PC, 32'h24);
        end
        Imem_ack = 1'b0;
        PC_LdEn = 1'b0;

        // Asynchronous reset in the middle of a WAIT.
        do_reset();
        fetch(0, 32'h0);
        advance(1'b1, 32'h8, 32'h0, 32'h24);
        tick();
        tick();
        check("mid_wait_req", 32'(Imem_req), 32'd1);
        #3;
        Reset = 1'b1;
        #1;
        check("async_req", 32'(Imem_req), 32'd0);
        check("async_pc", PC, 32'h0);
        check("async_instr", Instr, 32'h0);
        check("async_valid", 32'(Instr_valid), 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick();
        fetch(0, 32'h0);

        // PC wrap from the top of the address space; LdEn during REQ/WAIT ignored.
        tick();
        w_reset = 1'b0;
        tick();
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_addr0", w_addr, WRAP_PC);
        w_ld = 1'b1;
        tick();
        check("wrap_ld_req", w_pc, WRAP_PC);
        tick();
        check("wrap_ld_wait", w_pc, WRAP_PC);
        check("wrap_wait_req", 32'(w_req), 32'd1);
        w_ld = 1'b0;
        w_ack = 1'b1;
        w_rdata = mem_word(WRAP_PC);
        tick();
        w_ack = 1'b0;
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_instr", w_instr, mem_word(WRAP_PC));
        w_ld = 1'b1;
        w_sel = 1'b0;
        tick();
        w_ld = 1'b0;
        check("wrap_pc", w_pc, 32'h0);
        check("wrap_addr1", w_addr, 32'h0);
        check("wrap_req1", 32'(w_req), 32'd1);

        // Randomized run against the PC model.
        model_pc = 32'h0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        prev_v = 1'b0;
        cur_pc = 32'h0;
        n_fetch = 0;
        do_reset();
        fork
            rand_driver();
            rand_monitor();
        join_any
        disable fork;
        check("rand_progress", 32'(n_fetch >= 40), 32'd1);
        check("rand_no_err", 32'(Fetch_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
